// File: rtl/fuzz_stim_misr_harness_pkg.sv
// Shared constants, FSM state type and LFSR step for the stimulus/MISR harness.
package fuzz_harness_pkg;

    localparam logic [31:0] LFSR_MASK   = 32'hA3000000;
    localparam logic [31:0] GOLDEN_STEP = 32'h9E3779B9;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // 32-bit Galois LFSR, right-shifting.
    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/fuzz_stim_misr_harness_if.sv
// Control, stimulus and response bundle between a run controller and the harness.
interface fuzz_stim_misr_harness_if #(
    parameter int IN_W  = 252,
    parameter int OUT_W = 199,
    parameter int CNT_W = 16
) ();
    logic             start;
    logic [31:0]      seed;
    logic [CNT_W-1:0] num_vectors;
    logic [OUT_W-1:0] expected_sig;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] resp;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] signature;
    logic             match;

    modport master (
        output start, seed, num_vectors, expected_sig, resp,
        input  stim, busy, done, signature, match
    );

    modport slave (
        input  start, seed, num_vectors, expected_sig, resp,
        output stim, busy, done, signature, match
    );
endinterface

// File: rtl/fuzz_stim_misr_harness_misr_compactor.sv
// Multiple-input signature register folding one response word per enabled clock.
module misr_compactor #(
    parameter int              OUT_W     = 199,
    parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(32'h1D)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [OUT_W-1:0] resp,
    output logic [OUT_W-1:0] sig
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? MISR_POLY : '0) ^ resp;
        end
    end

endmodule

// File: rtl/fuzz_stim_misr_harness.sv
// LFSR-driven stimulus generator with MISR response compaction and golden compare.
module fuzz_stim_misr_harness
    import fuzz_harness_pkg::*;
#(
    parameter int              IN_W      = 252,
    parameter int              OUT_W     = 199,
    parameter int              HOLD      = 1,
    parameter int              DUT_LAT   = 0,
    parameter int              CNT_W     = 16,
    parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(32'h1D)
) (
    input  logic                     clk,
    input  logic                     rst,
    fuzz_stim_misr_harness_if.slave  bus
);

    localparam int NW = (IN_W + 31) / 32;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t           state, state_nxt;
    logic [31:0]      lfsr;
    logic [HW-1:0]    hold_cnt;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] nvec;
    logic [IN_W-1:0]  stim;
    logic             match_r;
    logic [OUT_W-1:0] sig;
    logic [31:0]      seed_fix;
    logic             accept, absorb, hold_end, last_vec;

    // Each 32-bit word is the LFSR state salted by a per-word golden-ratio step.
    function automatic logic [IN_W-1:0] expand(input logic [31:0] l);
        logic [NW*32-1:0] w;
        w = '0;
        for (int k = 0; k < NW; k++) begin
            w[k*32 +: 32] = l ^ (32'(k) * GOLDEN_STEP);
        end
        return w[IN_W-1:0];
    endfunction

    assign seed_fix = (bus.seed == 32'h0) ? 32'h1 : bus.seed;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        absorb    = 1'b0;
        hold_end  = 1'b0;
        last_vec  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = (bus.num_vectors == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                absorb   = (hold_cnt == HW'(DUT_LAT));
                hold_end = (hold_cnt == HW'(HOLD - 1));
                last_vec = (vec_cnt == nvec - CNT_W'(1));
                if (hold_end && last_vec) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= 32'h1;
            hold_cnt <= '0;
            vec_cnt  <= '0;
            nvec     <= '0;
            stim     <= '0;
            match_r  <= 1'b0;
        end else if (accept) begin
            lfsr     <= seed_fix;
            nvec     <= bus.num_vectors;
            hold_cnt <= '0;
            vec_cnt  <= '0;
            match_r  <= 1'b0;
            stim     <= (bus.num_vectors == '0) ? '0 : expand(seed_fix);
        end else if (state == RUN) begin
            if (hold_end) begin
                hold_cnt <= '0;
                lfsr     <= lfsr_next(lfsr);
                if (last_vec) begin
                    stim <= '0;
                end else begin
                    vec_cnt <= vec_cnt + CNT_W'(1);
                    stim    <= expand(lfsr_next(lfsr));
                end
            end else begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end else if (state == DONE) begin
            match_r <= (sig == bus.expected_sig);
        end
    end

    misr_compactor #(
        .OUT_W     (OUT_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (absorb),
        .resp (bus.resp),
        .sig  (sig)
    );

    assign bus.stim      = stim;
    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.signature = sig;
    assign bus.match     = match_r;

endmodule
